hazard_scoreboard: RTL and testbench

- Parametrised decode-stage hazard unit for the pipelined core. It replaces per-stage comparator logic with a DEPTH-entry shift-register scoreboard of in-flight register writes.
- Sits beside the IF/ID register. It asserts stall to freeze PC and IF/ID and to inject a bubble into ID/EX. It also flags the first stall cycle, squashes entries on branch/jump flush, and counts stall cycles.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_scoreboard_sb_match.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 80 ++++++++
 tb/tb_hazard_scoreboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int MAX_REG_AW  = 8;

  // Addresses are zero-extended to MAX_REG_AW so one entry type serves every REG_AW up to 8.
  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] addr;
    logic                  load;
  } sbEntry_t;

  function automatic int selWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Per-read-port comparison against every scoreboard stage; yields a stall request and forward index.
// HAZARD_FWD_EN selects forwarding mode (only a load at stage 0 stalls) over stall-only mode.
module sb_match
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 3,
  parameter int DEPTH     = 3,
  parameter int RF_BYPASS = 0,
  parameter int SELW      = selWidth(DEPTH)
) (
  input  logic                 enable,
  input  logic [REG_AW-1:0]    rdAddr,
  input  sbEntry_t [DEPTH-1:0] sb,
  output logic                 stallReq,
  output logic [SELW-1:0]      fwdIdx
);

  logic [DEPTH-1:0] matchVec;

  // Load flags of older stages are carried along for the top level but never inspected here.
  logic unusedSb;
  assign unusedSb = ^sb;

  always_comb begin
    matchVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      matchVec[i] = enable && sb[i].valid && (sb[i].addr == MAX_REG_AW'(rdAddr));
      if ((RF_BYPASS != 0) && (i == DEPTH - 1)) matchVec[i] = 1'b0;
    end
  end

`ifdef HAZARD_FWD_EN
  // Scanning oldest to youngest lets the youngest eligible stage overwrite older ones.
  always_comb begin
    stallReq = matchVec[0] && sb[0].load;
    fwdIdx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (matchVec[i] && !((i == 0) && sb[0].load)) fwdIdx = SELW'(i + 1);
    end
  end
`else
  assign stallReq = |matchVec;
  assign fwdIdx   = '0;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: shift-register scoreboard of in-flight writes, stall/flush control.
// Optional macro HAZARD_FWD_EN enables forwarding selects and load-use-only stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int NUM_RD      = 2,
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 1,
  parameter int RF_BYPASS   = 0,
  localparam int SELW       = selWidth(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_RD*REG_AW-1:0] id_rd_addr,
  input  logic [NUM_RD-1:0]        id_rd_used,
  input  logic                     id_wr_en,
  input  logic [REG_AW-1:0]        id_wr_addr,
  input  logic                     id_mem_rd,
  input  logic                     flush,
  output logic                     stall,
  output logic                     start_stall,
  output logic [NUM_RD*SELW-1:0]   fwd_sel,
  output logic [STALL_CNT_W-1:0]   stall_cycles
);

  sbEntry_t [DEPTH-1:0]   sbQ;
  sbEntry_t               newEntry;
  logic                   stallQ;
  logic [STALL_CNT_W-1:0] stallCntQ;
  logic [NUM_RD-1:0]      portStall;
  logic                   insert;

  for (genvar j = 0; j < NUM_RD; j++) begin : genPort
    sb_match #(
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .RF_BYPASS(RF_BYPASS),
      .SELW     (SELW)
    ) uMatch (
      .enable  (id_valid && id_rd_used[j]),
      .rdAddr  (id_rd_addr[j*REG_AW +: REG_AW]),
      .sb      (sbQ),
      .stallReq(portStall[j]),
      .fwdIdx  (fwd_sel[j*SELW +: SELW])
    );
  end

  // Flush wins over a hazard: the stalled instruction is being squashed anyway.
  assign stall       = (|portStall) && !flush;
  assign start_stall = stall && !stallQ;
  assign insert      = id_valid && id_wr_en && !stall && !flush;

  always_comb begin
    newEntry       = '0;
    newEntry.valid = 1'b1;
    newEntry.addr  = MAX_REG_AW'(id_wr_addr);
    newEntry.load  = id_mem_rd;
  end

  // The scoreboard shifts every cycle, stalled or not, so stall length tracks the drain time.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbQ       <= '0;
      stallQ    <= 1'b0;
      stallCntQ <= '0;
    end else begin
      sbQ[0] <= insert ? newEntry : '0;
      for (int i = 1; i < DEPTH; i++) begin
        sbQ[i] <= (flush && ((i - 1) < FLUSH_DEPTH)) ? '0 : sbQ[i-1];
      end
      stallQ <= stall;
      if (stall && (stallCntQ != '1)) stallCntQ <= stallCntQ + STALL_CNT_W'(1);
    end
  end

  assign stall_cycles = stallCntQ;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table plus saturation, bypass and reset sequences.
module tb_hazard_scoreboard;

  localparam int REG_AW = 3;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam int SW     = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        v;
    logic [2:0]  p1;
    logic [2:0]  p0;
    logic [1:0]  used;
    logic        we;
    logic [2:0]  wa;
    logic        ld;
    logic        fl;
    logic        xStall;
    logic        xStart;
    logic [3:0]  xFwd;
    logic [15:0] xCnt;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     idValid;
  logic [NUM_RD*REG_AW-1:0] idRdAddr;
  logic [NUM_RD-1:0]        idRdUsed;
  logic                     idWrEn;
  logic [REG_AW-1:0]        idWrAddr;
  logic                     idMemRd;
  logic                     flush;
  logic                     stallA, startA, stallB, startB;
  logic [NUM_RD*SW-1:0]     fwdA, fwdB;
  logic [15:0]              cntA, cntB;

  int testsRun    = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_scoreboard dutA (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_rd_addr(idRdAddr), .id_rd_used(idRdUsed),
    .id_wr_en(idWrEn), .id_wr_addr(idWrAddr), .id_mem_rd(idMemRd), .flush(flush),
    .stall(stallA), .start_stall(startA), .fwd_sel(fwdA), .stall_cycles(cntA)
  );

  hazard_scoreboard #(.RF_BYPASS(1)) dutB (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_rd_addr(idRdAddr), .id_rd_used(idRdUsed),
    .id_wr_en(idWrEn), .id_wr_addr(idWrAddr), .id_mem_rd(idMemRd), .flush(flush),
    .stall(stallB), .start_stall(startB), .fwd_sel(fwdB), .stall_cycles(cntB)
  );

  function automatic vec_t mk(input logic v, input logic [2:0] p1, input logic [2:0] p0,
                              input logic [1:0] used, input logic we, input logic [2:0] wa,
                              input logic ld, input logic fl, input logic xStall,
                              input logic xStart, input logic [3:0] xFwd, input logic [15:0] xCnt);
    vec_t t;
    t.v = v; t.p1 = p1; t.p0 = p0; t.used = used; t.we = we; t.wa = wa; t.ld = ld; t.fl = fl;
    t.xStall = xStall; t.xStart = xStart; t.xFwd = xFwd; t.xCnt = xCnt;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    idValid  = t.v;
    idRdAddr = {t.p1, t.p0};
    idRdUsed = t.used;
    idWrEn   = t.we;
    idWrAddr = t.wa;
    idMemRd  = t.ld;
    flush    = t.fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    idValid = 1'b0; idRdAddr = '0; idRdUsed = '0; idWrEn = 1'b0;
    idWrAddr = '0; idMemRd = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " rst stall"}, 32'(stallA), 32'd0);
    checkOutput({tag, " rst start"}, 32'(startA), 32'd0);
    checkOutput({tag, " rst fwd"}, 32'(fwdA), 32'd0);
    checkOutput({tag, " rst cnt"}, 32'(cntA), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t idle, cons, satVec;
    int   satLen, satPeriods, satStalls, satExp;

    idle = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'h0, 16'd0);

`ifdef HAZARD_FWD_EN
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 2, 0, 0, 0, 0, 4'h0, 16'd0));
    vecs.push_back(mk(1, 0, 2, 2'b01, 1, 3, 0, 0, 0, 0, 4'h1, 16'd0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 4, 1, 0, 0, 0, 4'h0, 16'd0));
    vecs.push_back(mk(1, 0, 4, 2'b01, 1, 5, 0, 0, 1, 1, 4'h0, 16'd0));
    vecs.push_back(mk(1, 0, 4, 2'b01, 1, 5, 0, 0, 0, 0, 4'h2, 16'd1));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 5, 0, 0, 0, 0, 4'h0, 16'd1));
    vecs.push_back(mk(1, 5, 5, 2'b11, 0, 0, 0, 0, 0, 0, 4'h5, 16'd1));
    vecs.push_back(mk(0, 5, 5, 2'b11, 0, 0, 0, 0, 0, 0, 4'h0, 16'd1));
    satLen = 2; satStalls = 1; satPeriods = 100;
`else
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 2, 0, 0, 0, 0, 4'h0, 16'd0));
    vecs.push_back(mk(1, 1, 2, 2'b11, 1, 3, 0, 0, 1, 1, 4'h0, 16'd0));
    vecs.push_back(mk(1, 1, 2, 2'b11, 1, 3, 0, 0, 1, 0, 4'h0, 16'd1));
    vecs.push_back(mk(1, 1, 2, 2'b11, 1, 3, 0, 0, 1, 0, 4'h0, 16'd2));
    vecs.push_back(mk(1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, 4'h0, 16'd3));
    vecs.push_back(mk(1, 3, 5, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0, 16'd3));
    vecs.push_back(mk(0, 0, 3, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0, 16'd3));
    vecs.push_back(mk(1, 0, 3, 2'b01, 1, 4, 0, 0, 1, 1, 4'h0, 16'd3));
    vecs.push_back(mk(1, 0, 3, 2'b01, 1, 4, 0, 0, 0, 0, 4'h0, 16'd4));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 5, 0, 0, 0, 0, 4'h0, 16'd4));
    vecs.push_back(mk(1, 0, 5, 2'b01, 1, 6, 0, 1, 0, 0, 4'h0, 16'd4));
    vecs.push_back(mk(1, 4, 5, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0, 16'd4));
    vecs.push_back(mk(1, 0, 1, 2'b01, 1, 1, 0, 0, 0, 0, 4'h0, 16'd4));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 4'h0, 16'd4));
    vecs.push_back(mk(1, 1, 0, 2'b10, 0, 0, 0, 0, 1, 1, 4'h0, 16'd4));
    vecs.push_back(mk(1, 1, 0, 2'b10, 0, 0, 0, 0, 1, 0, 4'h0, 16'd5));
    vecs.push_back(mk(1, 1, 0, 2'b10, 0, 0, 0, 0, 1, 0, 4'h0, 16'd6));
    vecs.push_back(mk(1, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 4'h0, 16'd7));
    satLen = 4; satStalls = 3; satPeriods = 21846;
`endif

    doReset("table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d stall", i), 32'(stallA), 32'(vecs[i].xStall));
      checkOutput($sformatf("v%0d start", i), 32'(startA), 32'(vecs[i].xStart));
      checkOutput($sformatf("v%0d fwd", i), 32'(fwdA), 32'(vecs[i].xFwd));
      checkOutput($sformatf("v%0d cnt", i), 32'(cntA), 32'(vecs[i].xCnt));
    end

    // Producer reaches the last stage: only the non-bypassing instance may stall.
    doReset("bypass");
    cons = mk(1, 0, 6, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0, 16'd0);
    applyStimulus(mk(1, 0, 0, 2'b00, 1, 6, 0, 0, 0, 0, 4'h0, 16'd0));
    applyStimulus(idle);
    applyStimulus(idle);
    applyStimulus(cons);
    #1;
`ifdef HAZARD_FWD_EN
    checkOutput("nobypass stall", 32'(stallA), 32'd0);
    checkOutput("nobypass fwd", 32'(fwdA), 32'h3);
    checkOutput("bypass fwd", 32'(fwdB), 32'h0);
`else
    checkOutput("nobypass stall", 32'(stallA), 32'd1);
`endif
    checkOutput("bypass stall", 32'(stallB), 32'd0);
    applyStimulus(cons);
    #1;
    checkOutput("nobypass drained", 32'(stallA), 32'd0);
    checkOutput("bypass drained", 32'(stallB), 32'd0);

    // Self-dependent instruction repeated: periodic stall pattern drives the counter.
    doReset("sat");
`ifdef HAZARD_FWD_EN
    satVec = mk(1, 0, 1, 2'b01, 1, 1, 1, 0, 0, 0, 4'h0, 16'd0);
`else
    satVec = mk(1, 0, 1, 2'b01, 1, 1, 0, 0, 0, 0, 4'h0, 16'd0);
`endif
    satExp = satPeriods * satStalls;
    if (satExp > 65535) satExp = 65535;
    for (int k = 0; k < satPeriods * satLen; k++) applyStimulus(satVec);
    applyStimulus(satVec);
    #1;
    checkOutput("sat cnt", 32'(cntA), 32'(satExp));
    checkOutput("sat period start", 32'(stallA), 32'd0);
    applyStimulus(satVec);
    #1;
    checkOutput("mid stall", 32'(stallA), 32'd1);
    checkOutput("mid start", 32'(startA), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst mid stall", 32'(stallA), 32'd0);
    checkOutput("rst mid start", 32'(startA), 32'd0);
    checkOutput("rst mid fwd", 32'(fwdA), 32'd0);
    checkOutput("rst mid cnt", 32'(cntA), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
